// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, line levels and default sizing for the UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;
  localparam logic UART_IDLE_LEVEL   = 1'b1;
  localparam logic UART_STOP_LEVEL   = 1'b1;
  localparam int   UART_DATA_WIDTH   = 8;
  localparam int   UART_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter with a one-cycle bit_tick_o on the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clr_i,
  output logic bit_tick_o
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt_q;
  assign bit_tick_o = cnt_q == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else cnt_q <= bit_tick_o ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops characters from an external FIFO and sends them as 8N1-style UART frames.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  tx_state_t             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BW-1:0]         bit_q;
  logic                  tx_q;
  logic                  tick;
`ifdef UART_TX_PARITY_EN
  logic                  par_q;
`endif
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .clr_i      (reset || state_q == FETCH),
    .bit_tick_o (tick)
  );
  assign fifo_read_enable = state_q == IDLE && !fifo_empty && !reset;
  assign tx      = tx_q;
  assign busy    = state_q != IDLE;
  assign tx_done = state_q == STOP && tick;
  // tx is registered, so each transition drives the level of the bit being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= UART_IDLE_LEVEL;
      shift_q <= '0;
      bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) state_q <= FETCH;
        FETCH: begin
          shift_q <= fifo_read_data;
          bit_q   <= '0;
          tx_q    <= 1'b0;
          state_q <= START;
`ifdef UART_TX_PARITY_EN
          par_q   <= ^fifo_read_data;
`endif
        end
        START: if (tick) begin
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
          state_q <= DATA;
        end
        DATA: if (tick) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
            tx_q    <= par_q;
            state_q <= PARITY;
`else
            tx_q    <= UART_STOP_LEVEL;
            state_q <= STOP;
`endif
          end else begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          tx_q    <= UART_STOP_LEVEL;
          state_q <= STOP;
        end
`endif
        STOP: if (tick) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: randomized frame checks of uart_fifo_tx against a bit-level frame model and a FIFO model.
module tb_uart_fifo_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FL = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic [DW-1:0] fifo_read_data = '0;
  logic          tx, busy, tx_done;
  logic [DW-1:0] mem [0:255];
  int            wp = 0;
  int            rp = 0;
  int            vectors = 0;
  int            miscompares = 0;

  uart_fifo_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .tx               (tx),
    .busy             (busy),
    .tx_done          (tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (fifo_read_enable) begin
      fifo_read_data <= mem[rp[7:0]];
      rp <= rp + 1;
    end
  end

  function automatic logic exp_tx(input logic [DW-1:0] b, input int k);
    int idx;
    idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return 1'(int'(b) >> (idx - 1));
`ifdef UART_TX_PARITY_EN
    if (idx == DW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic push(input logic [DW-1:0] b);
    mem[wp[7:0]] = b;
    wp++;
  endtask

  task automatic test_frame(input logic [DW-1:0] b, input bit at_pop);
    int n;
    n = 0;
    if (!at_pop) @(negedge clk);
    while (!fifo_read_enable && n < 8) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (fifo_read_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL pop_timeout: fifo_read_enable=%b required 1 (byte %h)", fifo_read_enable, b);
    end
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b1 || fifo_read_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch: tx=%b busy=%b rd=%b required 1 1 0 (byte %h)", tx, busy, fifo_read_enable, b);
    end
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      vectors++;
      if (tx !== exp_tx(b, k) || busy !== 1'b1 || tx_done !== (k == FL - 1) || fifo_read_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL frame byte %h cycle %0d: tx=%b busy=%b done=%b rd=%b required %b 1 %b 0",
                 b, k, tx, busy, tx_done, fifo_read_enable, exp_tx(b, k), k == FL - 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || fifo_read_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: tx=%b busy=%b done=%b rd=%b required 1 0 0 0", tx, busy, tx_done, fifo_read_enable);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (fifo_read_enable !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL idle cycle %0d: rd=%b tx=%b busy=%b required 0 1 0", i, fifo_read_enable, tx, busy);
      end
    end
  endtask

  task automatic test_a5();
    @(posedge clk); #1;
    push(8'hA5);
    test_frame(8'hA5, 1'b0);
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rp;
    @(posedge clk); #1;
    push(8'h00);
    push(8'hFF);
    test_frame(8'h00, 1'b0);
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap: tx=%b busy=%b rd=%b required 1 0 1", tx, busy, fifo_read_enable);
    end
    test_frame(8'hFF, 1'b1);
    @(negedge clk);
    vectors++;
    if (rp - r0 !== 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_pops: pops=%0d busy=%b required 2 0", rp - r0, busy);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      q.push_back(DW'($urandom));
      push(q[i]);
    end
    for (int i = 0; i < 6; i++) begin
      test_frame(q[i], i != 0);
      if (i != 5) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    @(posedge clk); #1;
    push(8'h3C);
    r0 = rp + 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k <= 4 * CPB + 1; k++) @(negedge clk);
    vectors++;
    if (tx !== exp_tx(8'h3C, 4 * CPB + 1) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_bit3: tx=%b busy=%b required %b 1", tx, busy, exp_tx(8'h3C, 4 * CPB + 1));
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: tx=%b busy=%b rd=%b required 1 0 0", tx, busy, fifo_read_enable);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (fifo_read_enable !== 1'b0 || tx !== 1'b1 || busy !== 1'b0 || rp !== r0) begin
        miscompares++;
        $display("FAIL post_reset %0d: rd=%b tx=%b busy=%b pops=%0d required 0 1 0 %0d", i, fifo_read_enable, tx, busy, rp, r0);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    @(posedge clk); #1;
    push(8'h07);
    push(8'h03);
    test_frame(8'h07, 1'b0);
    @(negedge clk);
    test_frame(8'h03, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_a5();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
